// File: rtl/shiftreg_sequencer.sv
// ---------------------------------------------------------------------------
// shiftreg_sequencer
//
// Command-driven controller for a 4-bit universal shift register.
// It accepts one command at a time over a valid/ready handshake and runs it
// as a series of register steps. A free-running prescaler paces the steps.
// When a command finishes, done pulses for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     operation code: NOP, LOAD, SHR, SHL, ROR, ROL, SERIAL_IN, CLEAR
//   cmd_cnt    step count for the shift/rotate ops
//   cmd_data   load value, or the serial-in bit pattern
//   cmd_fill   serial fill bit for SHR/SHL
//   A          register contents
//   s_mon      mode applied on the most recent step (00 when idle)
//   busy       command in progress
//   done       one-cycle completion pulse
//   err        one-cycle pulse when a rotate op is rejected
//
// Configuration macro: SHSEQ_ROTATE_EN
//   When defined, ROR/ROL execute normally.
//   When undefined, ROR/ROL are accepted, then rejected with an err pulse.
// ---------------------------------------------------------------------------
module shiftreg_sequencer #(
    parameter int DIV_W = 26
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    output logic [3:0] A,
    output logic [1:0] s_mon,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SHR    = 3'b010;
    localparam logic [2:0] OP_SHL    = 3'b011;
    localparam logic [2:0] OP_ROR    = 3'b100;
    localparam logic [2:0] OP_ROL    = 3'b101;
    localparam logic [2:0] OP_SERIAL = 3'b110;
    localparam logic [2:0] OP_CLEAR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] prescale;
    logic             tick;
    logic [2:0]       op_q;
    logic [3:0]       data_q;
    logic             fill_q;
    logic [2:0]       step_cnt;
    logic             err_q;
    logic             accept;
    logic             rot_reject;
    logic             zero_len;
    logic [2:0]       load_cnt;
    logic [1:0]       mode;
    logic             ser_in;
    logic [3:0]       next_a;

    assign tick   = &prescale;
    assign accept = cmd_valid && cmd_ready;

`ifdef SHSEQ_ROTATE_EN
    assign rot_reject = 1'b0;
`else
    assign rot_reject = (cmd_op == OP_ROR) || (cmd_op == OP_ROL);
`endif

    // These commands need no register step, so they go straight to FIN:
    // NOP, and a shift or rotate op with a count of zero.
    assign zero_len = (cmd_op == OP_NOP) ||
                      (((cmd_op == OP_SHR) || (cmd_op == OP_SHL) ||
                        (cmd_op == OP_ROR) || (cmd_op == OP_ROL)) && (cmd_cnt == 3'd0));

    always_comb begin
        load_cnt = cmd_cnt;
        case (cmd_op)
            OP_LOAD, OP_CLEAR: load_cnt = 3'd1;
            OP_SERIAL:         load_cnt = 3'd4;
            default:           load_cnt = cmd_cnt;
        endcase
    end

    // Step datapath.
    // SERIAL_IN reads its input bit from data_q[0]. The data register
    // shifts right after each step, so data_q[0] holds bit k on step k.
    always_comb begin
        mode   = 2'b00;
        ser_in = 1'b0;
        next_a = A;
        case (op_q)
            OP_LOAD, OP_CLEAR: mode = 2'b11;
            OP_SHR, OP_ROR, OP_SERIAL: mode = 2'b01;
            OP_SHL, OP_ROL: mode = 2'b10;
            default: mode = 2'b00;
        endcase
        case (op_q)
            OP_SHR, OP_SHL: ser_in = fill_q;
            OP_ROR:         ser_in = A[0];
            OP_ROL:         ser_in = A[3];
            OP_SERIAL:      ser_in = data_q[0];
            default:        ser_in = 1'b0;
        endcase
        case (mode)
            2'b01:   next_a = {ser_in, A[3:1]};
            2'b10:   next_a = {A[2:0], ser_in};
            2'b11:   next_a = (op_q == OP_CLEAR) ? 4'b0000 : data_q;
            default: next_a = A;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    // A rejected rotate stays in IDLE. Only err reports the rejection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rot_reject)    state_d = IDLE;
                    else if (zero_len) state_d = FIN;
                    else               state_d = RUN;
                end
            end
            RUN: begin
                if (tick && (step_cnt == 3'd1)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    // Gating with clear stops a done or ready from showing while reset is
    // being applied.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !clear;
        busy      = ((state_q == RUN) || (state_q == FIN)) && !clear;
        done      = (state_q == FIN) && !clear;
        err       = err_q && !clear;
    end

    // Prescaler, command capture and register update.
    always_ff @(posedge clk) begin
        if (clear) begin
            prescale <= '0;
            A        <= 4'b0000;
            s_mon    <= 2'b00;
            op_q     <= OP_NOP;
            data_q   <= 4'b0000;
            fill_q   <= 1'b0;
            step_cnt <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            prescale <= prescale + DIV_W'(1);
            err_q    <= accept && rot_reject;
            if (accept) begin
                op_q     <= cmd_op;
                data_q   <= cmd_data;
                fill_q   <= cmd_fill;
                step_cnt <= load_cnt;
            end
            if ((state_q == RUN) && tick) begin
                A        <= next_a;
                s_mon    <= mode;
                step_cnt <= step_cnt - 3'd1;
                if (op_q == OP_SERIAL) data_q <= {1'b0, data_q[3:1]};
            end else if (state_q == FIN) begin
                s_mon <= 2'b00;
            end
        end
    end

endmodule
